mmio_bridge: RTL and testbench

- Sits directly downstream of the pipelined MIPS core's M stage. Consumes the core's aluout (byte address), writedata and memwrite, and produces the readdata the core latches into its W stage.
- Decodes each address to one of three targets: the external word-addressed data memory, a small on-block peripheral set (GPIO, cycle counter, 4-deep transmit FIFO with valid/ready sink), or unmapped space.
- The read path is combinational, so the core needs no stall.

---
 rtl/mmio_bridge_pkg.sv | 18 +
 rtl/mmio_bridge_tx_fifo.sv | 48 ++++
 rtl/mmio_bridge.sv | 108 ++++++++++
 tb/tb_mmio_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared constants for the M-stage memory/peripheral bridge: I/O window base,
// register offsets and status bit layout.
package mmio_bridge_pkg;
  localparam logic [15:0] IO_BASE       = 16'hFFFF;

  localparam logic [15:0] GPIO_OUT_OFF  = 16'h0000;
  localparam logic [15:0] GPIO_IN_OFF   = 16'h0004;
  localparam logic [15:0] CYCLE_OFF     = 16'h0008;
  localparam logic [15:0] TX_DATA_OFF   = 16'h000C;
  localparam logic [15:0] TX_STATUS_OFF = 16'h0010;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {TGT_NONE, TGT_DMEM, TGT_IO} tgt_e;
endpackage

// File: rtl/mmio_bridge_tx_fifo.sv
// Small transmit FIFO; head entry is presented straight from storage so the
// output never depends combinationally on the write data.
module tx_fifo #(
  parameter int WIDTH   = 8,
  parameter int TXDEPTH = 4,
  parameter int TXPTRW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [TXPTRW:0]   count
);
  logic [WIDTH-1:0]  mem [TXDEPTH];
  logic [TXPTRW-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (TXPTRW+1)'(TXDEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees a slot in the same edge, so a full FIFO still takes the push
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + TXPTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + TXPTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (TXPTRW+1)'(1);
        2'b01:   count <= count - (TXPTRW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_bridge.sv
// Address decode between the core's M stage and data memory / on-block
// peripherals (GPIO, cycle counter, transmit FIFO). Loads are combinational.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DMEMDEPTH = 14,
  parameter int GPIOW     = 8,
  parameter int TXDEPTH   = 4,
  parameter int TXPTRW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 we,
  output logic [WIDTH-1:0]     rd,
  output logic [DMEMDEPTH-1:0] dmem_addr,
  output logic                 dmem_we,
  output logic [WIDTH-1:0]     dmem_wd,
  input  logic [WIDTH-1:0]     dmem_rd,
  output logic [GPIOW-1:0]     gpio_out,
  input  logic [GPIOW-1:0]     gpio_in,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);
  logic             dmem_sel, io_sel;
  logic [15:0]      offset, word_off;
  tgt_e             tgt;
  logic [WIDTH-1:0] io_rd;
  logic [WIDTH-1:0] cycle;
  logic [GPIOW-1:0] gsync1, gsync2;
  logic             ovf;
  logic             io_we, push_req, pop, tx_full, tx_empty;
  logic [TXPTRW:0]  tx_count;

  assign dmem_sel  = (addr[WIDTH-1:DMEMDEPTH+2] == '0);
  assign io_sel    = (addr[WIDTH-1:16] == IO_BASE);
  assign offset    = addr[15:0];
  assign word_off  = offset & 16'hFFFC;
  assign dmem_addr = addr[DMEMDEPTH+1:2];
  assign dmem_wd   = wd;
  assign dmem_we   = we & dmem_sel;

  assign io_we    = we & io_sel;
  assign push_req = io_we & (word_off == TX_DATA_OFF);
  assign tx_valid = ~tx_empty;
  assign pop      = tx_valid & tx_ready;

  tx_fifo #(.WIDTH(8), .TXDEPTH(TXDEPTH), .TXPTRW(TXPTRW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (wd[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= '0;
      cycle    <= '0;
      gsync1   <= '0;
      gsync2   <= '0;
      ovf      <= 1'b0;
    end else begin
      gsync1 <= gpio_in;
      gsync2 <= gsync1;
      if (io_we && word_off == GPIO_OUT_OFF) gpio_out <= wd[GPIOW-1:0];
      if (io_we && word_off == CYCLE_OFF) cycle <= wd;
      else                                 cycle <= cycle + WIDTH'(1);
      // only one register is addressed per cycle, so set and clear never collide
      if (io_we && word_off == TX_STATUS_OFF)   ovf <= 1'b0;
      else if (push_req && tx_full && !pop)     ovf <= 1'b1;
    end
  end

  always_comb begin
    io_rd = '0;
    case (word_off)
      GPIO_OUT_OFF:  io_rd[GPIOW-1:0] = gpio_out;
      GPIO_IN_OFF:   io_rd[GPIOW-1:0] = gsync2;
      CYCLE_OFF:     io_rd = cycle;
      TX_STATUS_OFF: begin
        io_rd[ST_FULL]                   = tx_full;
        io_rd[ST_EMPTY]                  = tx_empty;
        io_rd[ST_OVF]                    = ovf;
        io_rd[ST_CNT_LSB +: TXPTRW+1]    = tx_count;
      end
      default: ;
    endcase
  end

  always_comb begin
    tgt = TGT_NONE;
    if (dmem_sel)    tgt = TGT_DMEM;
    else if (io_sel) tgt = TGT_IO;
    case (tgt)
      TGT_DMEM: rd = dmem_rd;
      TGT_IO:   rd = io_rd;
      default:  rd = '0;
    endcase
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed plus randomized bench for mmio_bridge against a queue-based
// reference model of the peripheral set.
module tb_mmio_bridge;
  localparam int TXD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wd, rd, dmem_wd, dmem_rd;
  logic        we, dmem_we;
  logic [13:0] dmem_addr;
  logic [7:0]  gpio_out, gpio_in, tx_data;
  logic        tx_valid, tx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [7:0]  gpio_m, s1_m, s2_m;
  logic [31:0] cyc_m;
  logic        ovf_m;

  always #5 clk = ~clk;

  // data-memory stand-in: a known function of the word index
  assign dmem_rd = {18'h0, dmem_addr} ^ 32'hA5A5_0000;

  mmio_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wd        (wd),
    .we        (we),
    .rd        (rd),
    .dmem_addr (dmem_addr),
    .dmem_we   (dmem_we),
    .dmem_wd   (dmem_wd),
    .dmem_rd   (dmem_rd),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  function automatic logic [31:0] io_exp(logic [15:0] off);
    logic [31:0] v;
    v = 32'h0;
    case (off & 16'hFFFC)
      16'h0000: v = {24'h0, gpio_m};
      16'h0004: v = {24'h0, s2_m};
      16'h0008: v = cyc_m;
      16'h0010: v = (q.size() == TXD ? 32'h1 : 32'h0) | (q.size() == 0 ? 32'h2 : 32'h0)
                  | (ovf_m ? 32'h4 : 32'h0) | (32'(q.size()) << 4);
      default:  v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rd_exp(logic [31:0] a);
    if (a[31:16] == 16'h0000) return {18'h0, a[15:2]} ^ 32'hA5A5_0000;
    if (a[31:16] == 16'hFFFF) return io_exp(a[15:0]);
    return 32'h0;
  endfunction

  task automatic model_reset();
    q.delete();
    gpio_m = 8'h0; s1_m = 8'h0; s2_m = 8'h0; cyc_m = 32'h0; ovf_m = 1'b0;
  endtask

  // what the registered state becomes at the coming edge, given current inputs
  task automatic model_edge();
    logic        io, popm, pushm;
    logic [15:0] o;
    io    = (addr[31:16] == 16'hFFFF);
    o     = addr[15:0] & 16'hFFFC;
    popm  = (q.size() != 0) && tx_ready;
    pushm = we && io && (o == 16'h000C);
    s2_m = s1_m;
    s1_m = gpio_in;
    if (we && io && o == 16'h0008) cyc_m = wd;
    else                           cyc_m = cyc_m + 32'd1;
    if (we && io && o == 16'h0000) gpio_m = wd[7:0];
    if (we && io && o == 16'h0010) ovf_m = 1'b0;
    if (popm) void'(q.pop_front());
    if (pushm) begin
      if (q.size() < TXD) q.push_back(wd[7:0]);
      else                ovf_m = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] expv);
    addr = a; we = 1'b0;
    #1;
    chk(tag, rd, expv);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [31:0] a;
    rst = 1'b1; addr = 32'h0; wd = 32'h0; we = 1'b0; tx_ready = 1'b0; gpio_in = 8'h0;
    model_reset();

    // reset state and counter start
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    rst = 1'b0;
    rdchk("rst_status", 32'hFFFF_0010, 32'h0000_0002);
    tick(); tick();
    rdchk("cycle_2", 32'hFFFF_0008, 32'd2);
    tick();
    rdchk("cycle_3", 32'hFFFF_0008, 32'd3);

    // decode and dmem strobe
    addr = 32'h0000_0010; wd = 32'h1234_5678; we = 1'b1;
    #1;
    chk("dmem_we_hit", {31'h0, dmem_we}, 32'h1);
    chk("dmem_addr", {18'h0, dmem_addr}, 32'd4);
    chk("dmem_wd", dmem_wd, 32'h1234_5678);
    addr = 32'hFFFF_0000;
    #1;
    chk("dmem_we_io", {31'h0, dmem_we}, 32'h0);
    addr = 32'h0010_0000;
    #1;
    chk("dmem_we_unmapped", {31'h0, dmem_we}, 32'h0);
    rdchk("rd_unmapped", 32'h0010_0000, 32'h0);
    rdchk("rd_dmem", 32'h0000_0010, 32'hA5A5_0004);
    tick();

    // GPIO out and input synchronizer
    wr(32'hFFFF_0000, 32'hDEAD_BEA5);
    chk("gpio_out", {24'h0, gpio_out}, 32'hA5);
    rdchk("gpio_out_rd", 32'hFFFF_0000, 32'h0000_00A5);
    gpio_in = 8'h3C;
    rdchk("gpio_in_0edge", 32'hFFFF_0004, 32'h0);
    tick();
    rdchk("gpio_in_1edge", 32'hFFFF_0004, 32'h0);
    tick();
    rdchk("gpio_in_2edge", 32'hFFFF_0004, 32'h3C);

    // overflow then drain
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'hFFFF_000C, {24'h0, seq[i]});
    rdchk("status_ovf_full", 32'hFFFF_0010, 32'h0000_0045);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'h0, tx_valid}, 32'h1);
      chk("drain_data", {24'h0, tx_data}, {24'h0, seq[i]});
      tick();
    end
    chk("drained_valid", {31'h0, tx_valid}, 32'h0);
    rdchk("status_empty_ovf", 32'hFFFF_0010, 32'h0000_0006);
    wr(32'hFFFF_0010, 32'h0);
    rdchk("status_ovf_clr", 32'hFFFF_0010, 32'h0000_0002);

    // push into a full FIFO while it pops
    seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h66};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'hFFFF_000C, {24'h0, seq[i]});
    tx_ready = 1'b1;
    wr(32'hFFFF_000C, 32'h0000_0066);
    rdchk("status_full_pp", 32'hFFFF_0010, 32'h0000_0041);
    for (int i = 1; i < 5; i++) begin
      chk("pp_valid", {31'h0, tx_valid}, 32'h1);
      chk("pp_data", {24'h0, tx_data}, {24'h0, seq[i]});
      tick();
    end
    chk("pp_drained", {31'h0, tx_valid}, 32'h0);

    // cycle counter load and wrap
    wr(32'hFFFF_0008, 32'hFFFF_FFFE);
    rdchk("cycle_load", 32'hFFFF_0008, 32'hFFFF_FFFE);
    tick();
    rdchk("cycle_ffff", 32'hFFFF_0008, 32'hFFFF_FFFF);
    tick();
    rdchk("cycle_wrap", 32'hFFFF_0008, 32'h0);

    // reset mid-drain with three bytes left
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'hFFFF_000C, 32'h70 + 32'(i));
    tx_ready = 1'b1;
    tick();
    chk("mid_valid", {31'h0, tx_valid}, 32'h1);
    rdchk("mid_status", 32'hFFFF_0010, 32'h0000_0030);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'h0, tx_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rdchk("rst_mid_status", 32'hFFFF_0010, 32'h0000_0002);
    chk("rst_mid_gpio", {24'h0, gpio_out}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: a = {16'h0000, 16'($urandom)};
        1: a = 32'hFFFF_000C | 32'($urandom_range(0, 3));
        2, 3: a = 32'hFFFF_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        default: a = 32'h0010_0000 | ($urandom & 32'h7FEF_FFFF);
      endcase
      addr = a;
      wd = $urandom;
      we = ($urandom_range(0, 1) == 1);
      tx_ready = ($urandom_range(0, 9) < (i < 200 ? 1 : 6));
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      #1;
      chk("rnd_rd", rd, rd_exp(a));
      chk("rnd_dmem_we", {31'h0, dmem_we}, {31'h0, we && a[31:16] == 16'h0});
      chk("rnd_tx_valid", {31'h0, tx_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) chk("rnd_tx_data", {24'h0, tx_data}, {24'h0, q[0]});
      chk("rnd_gpio_out", {24'h0, gpio_out}, {24'h0, gpio_m});
      tick();
    end
    we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
